fd_edge_reg_bank: RTL and testbench

- Parametrised successor to the single-bit preset D-type latch cell.
- A WIDTH-bit register bank running entirely in the MasterClock domain. The slow cell clock `clk` is sampled and edge-detected rather than used as a real clock.
- On each detected active edge the bank holds, parallel-loads, shifts left or shifts right, according to `mode`.
- Used wherever chip-level cells need multi-bit latches, shift registers or capture registers that stay synchronous to MasterClock.

---
 rtl/fd_edge_reg_bank.sv | 86 ++++++++
 tb/tb_fd_edge_reg_bank.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fd_edge_reg_bank.sv
// WIDTH-bit hold/load/shift register bank clocked by MasterClock.
// The slow cell clock is sampled and edge-detected and acts as a capture enable.
module fd_edge_reg_bank #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
    parameter bit               FALLING   = 1'b0
) (
    input  logic             MasterClock,
    input  logic             rL,
    input  logic             clk,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qL,
    output logic             sout,
    output logic             strobe
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_SHR  = 2'b11;

    // Reset history equals the "already at the inactive-to-active level" state,
    // so releasing reset with clk at any level never looks like an edge.
    localparam logic [1:0] HIST_RST = FALLING ? 2'b00 : 2'b11;
    localparam logic [1:0] HIST_CAP = FALLING ? 2'b10 : 2'b01;

    logic [1:0]       hist_q,   hist_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic             strobe_q, strobe_d;
    logic             cap;
    logic [WIDTH-1:0] shl_val,  shr_val;

    generate
        if (WIDTH == 1) begin : g_w1
            assign shl_val = sin;
            assign shr_val = sin;
        end else begin : g_wn
            assign shl_val = {data_q[WIDTH-2:0], sin};
            assign shr_val = {sin, data_q[WIDTH-1:1]};
        end
    endgenerate

    assign cap = (hist_q == HIST_CAP);

    always_comb begin
        hist_d   = {hist_q[0], clk};
        data_d   = data_q;
        strobe_d = cap;
        if (cap) begin
            case (mode)
                MODE_HOLD: data_d = data_q;
                MODE_LOAD: data_d = d;
                MODE_SHL:  data_d = shl_val;
                MODE_SHR:  data_d = shr_val;
                default:   data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge MasterClock or negedge rL) begin
        if (!rL) begin
            hist_q   <= HIST_RST;
            data_q   <= RESET_VAL;
            strobe_q <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < int'(WIDTH); gi++) begin : g_inv
            assign qL[gi] = ~data_q[gi];
        end
    endgenerate

    assign q      = data_q;
    assign strobe = strobe_q;
    assign sout   = (mode == MODE_SHL) ? data_q[WIDTH-1] : data_q[0];

endmodule

// File: tb/tb_fd_edge_reg_bank.sv
// Directed bench: rising-edge and falling-edge banks share stimulus; table of
// single-edge vectors plus hand-written reset, miss and falling-edge sequences.
module tb_fd_edge_reg_bank;

    logic       mclk = 1'b0;
    logic       rL   = 1'b1;
    logic       cclk = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [7:0] d    = 8'h00;
    logic       sin  = 1'b0;

    logic [7:0] q0, qL0, q1, qL1;
    logic       sout0, strobe0, sout1, strobe1;

    int checks = 0;
    int errors = 0;

    always #5 mclk = ~mclk;

    fd_edge_reg_bank #(.WIDTH(8), .RESET_VAL(8'hFF), .FALLING(1'b0)) dut0 (
        .MasterClock(mclk), .rL(rL), .clk(cclk), .mode(mode), .d(d), .sin(sin),
        .q(q0), .qL(qL0), .sout(sout0), .strobe(strobe0)
    );

    fd_edge_reg_bank #(.WIDTH(8), .RESET_VAL(8'hFF), .FALLING(1'b1)) dut1 (
        .MasterClock(mclk), .rL(rL), .clk(cclk), .mode(mode), .d(d), .sin(sin),
        .q(q1), .qL(qL1), .sout(sout1), .strobe(strobe1)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] d;
        logic       sin;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] q_of(input int w);
        return (w != 0) ? q1 : q0;
    endfunction

    function automatic logic [7:0] ql_of(input int w);
        return (w != 0) ? qL1 : qL0;
    endfunction

    function automatic logic str_of(input int w);
        return (w != 0) ? strobe1 : strobe0;
    endfunction

    function automatic logic sout_of(input int w);
        return (w != 0) ? sout1 : sout0;
    endfunction

    // Drive cclk to lvl, check the two-posedge latency and one-cycle strobe,
    // then return cclk to the opposite level and let it settle.
    task automatic edge_check(input int w, input logic lvl, input logic [7:0] old_q,
                              input logic [7:0] exp, input string name);
        logic exp_sout;
        cclk = lvl;
        tick();
        chk({name, " q before"}, q_of(w), old_q);
        chk({name, " strobe before"}, {7'd0, str_of(w)}, 8'd0);
        tick();
        exp_sout = (mode == 2'b10) ? exp[7] : exp[0];
        chk({name, " q"}, q_of(w), exp);
        chk({name, " qL"}, ql_of(w), ~exp);
        chk({name, " sout"}, {7'd0, sout_of(w)}, {7'd0, exp_sout});
        chk({name, " strobe"}, {7'd0, str_of(w)}, 8'd1);
        tick();
        chk({name, " strobe after"}, {7'd0, str_of(w)}, 8'd0);
        tick();
        cclk = ~lvl;
        tick();
        tick();
        $display("edge %s: mode=%b d=%h sin=%b q=%h strobe_seen", name, mode, d, sin, q_of(w));
    endtask

    initial begin
        logic [7:0] prev;

        vecs[0] = '{2'b01, 8'hA5, 1'b0, 8'hA5};
        vecs[1] = '{2'b01, 8'h81, 1'b0, 8'h81};
        vecs[2] = '{2'b10, 8'h00, 1'b1, 8'h03};
        vecs[3] = '{2'b10, 8'hFF, 1'b1, 8'h07};
        vecs[4] = '{2'b10, 8'h00, 1'b1, 8'h0F};
        vecs[5] = '{2'b01, 8'h81, 1'b1, 8'h81};
        vecs[6] = '{2'b11, 8'hFF, 1'b0, 8'h40};
        vecs[7] = '{2'b11, 8'h00, 1'b0, 8'h20};
        vecs[8] = '{2'b00, 8'hFF, 1'b1, 8'h20};
        vecs[9] = '{2'b11, 8'h00, 1'b1, 8'h90};

        // Reset asserted mid-cycle takes effect without a MasterClock edge.
        #17;
        rL = 1'b0;
        #1;
        chk("reset q", q0, 8'hFF);
        chk("reset qL", qL0, 8'h00);
        chk("reset strobe", {7'd0, strobe0}, 8'd0);
        tick();
        tick();
        rL = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("release hold %0d strobe", i), {7'd0, strobe0}, 8'd0);
            chk($sformatf("release hold %0d q", i), q0, 8'hFF);
        end
        $display("reset release with clk=1: q=%h", q0);

        cclk = 1'b0;
        tick();
        tick();

        prev = q0;
        for (int i = 0; i < 10; i++) begin
            mode = vecs[i].mode;
            d    = vecs[i].d;
            sin  = vecs[i].sin;
            tick();
            chk($sformatf("vec%0d sout pre", i), {7'd0, sout0},
                {7'd0, (mode == 2'b10) ? prev[7] : prev[0]});
            edge_check(0, 1'b1, prev, vecs[i].exp_q, $sformatf("vec%0d", i));
            prev = vecs[i].exp_q;
        end

        // No edge: q holds regardless of mode and d.
        mode = 2'b01;
        d    = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("no edge %0d q", i), q0, prev);
            chk($sformatf("no edge %0d strobe", i), {7'd0, strobe0}, 8'd0);
        end
        $display("no-edge hold: q=%h", q0);

        // Sub-cycle pulse lands between posedges and is legally missed.
        @(posedge mclk);
        #1 cclk = 1'b1;
        #5 cclk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("short pulse %0d q", i), q0, prev);
            chk($sformatf("short pulse %0d strobe", i), {7'd0, strobe0}, 8'd0);
        end
        $display("short pulse: q=%h", q0);

        // Reset during the capture cycle discards the pending load.
        d    = 8'h12;
        cclk = 1'b1;
        tick();
        #2 rL = 1'b0;
        #1;
        chk("rst in cap q", q0, 8'hFF);
        chk("rst in cap strobe", {7'd0, strobe0}, 8'd0);
        tick();
        chk("rst in cap held q", q0, 8'hFF);
        chk("rst in cap held strobe", {7'd0, strobe0}, 8'd0);
        rL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst cap release %0d strobe", i), {7'd0, strobe0}, 8'd0);
            chk($sformatf("rst cap release %0d q", i), q0, 8'hFF);
        end
        cclk = 1'b0;
        tick();
        tick();
        edge_check(0, 1'b1, 8'hFF, 8'h12, "post reset load");

        // Falling-edge bank: fresh reset with clk held high.
        cclk = 1'b1;
        tick();
        tick();
        #2 rL = 1'b0;
        #1;
        chk("fall reset q", q1, 8'hFF);
        tick();
        rL = 1'b1;
        mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("fall release %0d strobe", i), {7'd0, strobe1}, 8'd0);
        end
        edge_check(1, 1'b0, 8'hFF, 8'hFF, "fall hold");
        // edge_check left clk high; step back to low to set up the rising test.
        mode = 2'b00;
        cclk = 1'b0;
        tick();
        tick();
        tick();
        tick();
        mode = 2'b01;
        d    = 8'h5A;
        cclk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("fall rise ignored %0d q", i), q1, 8'hFF);
            chk($sformatf("fall rise ignored %0d strobe", i), {7'd0, strobe1}, 8'd0);
        end
        edge_check(1, 1'b0, 8'hFF, 8'h5A, "fall load");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
